// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC, 2-entry fetch buffer, redirect
module ifetch_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state for the two-slot ring: flush wins, otherwise push and pop are independent
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Ring storage and pointers; reset empties the buffer and clears its contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is forced to zero while empty so decode never sees stale data
  always_comb begin
    head_data = '0;
    if (count_q != 2'd0) begin
      head_data = mem_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_inst,
  output logic [31:0]       dec_pc,
  output logic              misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  count;
  logic [63:0] head_data;
  logic        pop;
  logic        can_push;

  // Handshake: a pop still completes during a redirect; pushes need room or a same-cycle pop
  always_comb begin
    pop      = dec_valid & dec_ready;
    can_push = fetch_en & ~redirect_valid & ((count < 2'd2) | pop);
  end

  // PC and misalignment flag next-state: redirect overrides sequential advance
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
    end else if (can_push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  ifetch_buf #(
    .W (64)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (can_push),
    .push_data ({pc_q, rom_inst}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  // Outputs: ROM address follows the live PC; decode sees the buffer head
  always_comb begin
    rom_addr     = pc_q[ADDR_W+1:2];
    dec_valid    = (count != 2'd0);
    dec_pc       = head_data[63:32];
    dec_inst     = head_data[31:0];
    misalign_err = misalign_q;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front end that drives the word address of the combinational instruction ROM, captures the returned instruction, and presents it with its PC to decode through a valid/ready handshake. It owns the program counter, a 2-entry fetch buffer that absorbs decode back-pressure, and redirection on taken branches and jumps. It sits between the ROM and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction (bits [1:0] must be 0)
- ADDR_W, 20, width of the ROM word address
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  when 1, new fetches are allowed; when 0, the buffer only drains
- rom_addr  out  ADDR_W  ROM word address, equal to pc[ADDR_W+1:2]
- rom_inst  in  32  ROM data for rom_addr, valid in the same cycle (combinational ROM)
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc
- redirect_pc  in  32  new byte-address PC
- dec_valid  out  1  buffer head holds an instruction
- dec_ready  in  1  decode accepts the head this cycle
- dec_inst  out  32  head instruction; 0 when empty
- dec_pc  out  32  head byte-address PC; 0 when empty
- misalign_err  out  1  registered one-cycle pulse: the last redirect had redirect_pc[1:0] != 0

## Operation
- State: pc (32 bits), 2-entry FIFO of {pc, inst}, count (0..2), misalign_err flop.
- pop = dec_valid & dec_ready. can_push = fetch_en & ~redirect_valid & (count < 2 | pop).
- Push: on can_push, write {pc, rom_inst} to the tail and set pc <= pc + 4 (modulo 2^32).
- Pop and push can occur in the same cycle; count is unchanged, and entries stay in order.
- Redirect has priority over everything else:
  - A pop in the same cycle still completes, because decode has consumed that instruction.
  - There is no push in the redirect cycle.
  - At the edge: FIFO flushed (count <= 0), pc <= {redirect_pc[31:2], 2'b00}, misalign_err <= |redirect_pc[1:0].
- In any non-redirect cycle, misalign_err <= 0.
- fetch_en = 0: pc frozen, no push; pops continue until empty.
- rom_addr always reflects the current pc, including when no push occurs.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. rom_addr takes pc[ADDR_W+1:2] and ignores the upper bits.
- dec_inst and dec_pc are combinational from the head entry, forced to 0 when count == 0.

## Timing
- Reset values (async assert, while rst_n = 0):
  - pc = RESET_PC, count = 0
  - dec_valid = 0, dec_inst = 0, dec_pc = 0
  - misalign_err = 0
  - rom_addr = RESET_PC[ADDR_W+1:2]
- Reset deasserted mid-operation (async assert): buffer contents are lost; fetch restarts at RESET_PC.
- Fetch latency: instruction at pc is pushed at the edge ending cycle N and is visible on dec_* in cycle N+1.
- After reset release, with fetch_en = 1: first edge pushes RESET_PC, and dec_valid = 1 on the following cycle.
- With dec_ready = 1 held: throughput 1 instruction/cycle, count steady at 1.
- With dec_ready = 0 held: count reaches 2 after two pushes, then pc stops and rom_addr is held. When dec_ready returns, fetch resumes in that same cycle (push with pop).
- Redirect in cycle R:
  - Cycle R+1: dec_valid = 0, rom_addr = target word address.
  - Cycle R+2: dec_valid = 1, dec_pc = target.
  - Redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins; each one flushes the buffer.
- Handshake rule: dec_inst and dec_pc are stable while dec_valid = 1 and dec_ready = 0, unless a redirect occurs.

## Test plan
- Reset/stream:
  - Stimulus: ROM word k = 32'h1000_0000 + k; RESET_PC = 0; release rst_n; fetch_en = 1, dec_ready = 1.
  - Response: from the second cycle, dec_pc = 0, 4, 8, ... and dec_inst = 32'h1000_0000, 32'h1000_0001, ... with no gaps.
- Back-pressure:
  - Stimulus: drop dec_ready for 5 cycles, then raise it.
  - Response: count saturates at 2; rom_addr holds; dec_inst is stable; afterwards the stream continues with no loss or duplication.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc = 32'h0000_0100 while count = 2.
  - Response: next cycle dec_valid = 0 and rom_addr = 20'h40; the cycle after, dec_pc = 32'h100 and dec_inst = 32'h1000_0040.
- Misaligned redirect:
  - Stimulus: redirect_pc = 32'h0000_0102.
  - Response: misalign_err = 1 for exactly one cycle; fetch resumes at 32'h100.
- fetch_en low:
  - Stimulus: deassert fetch_en with count = 2 and dec_ready = 1.
  - Response: two more instructions are delivered, then dec_valid = 0; pc is unchanged until fetch_en returns.
- Wrap and reset mid-run:
  - Stimulus: redirect to 32'hFFFF_FFFC, then assert rst_n low while count = 2.
  - Response: dec_pc goes 32'hFFFF_FFFC then 32'h0000_0000. On reset, all outputs go to their reset values immediately, and fetch restarts at RESET_PC.
